// File: rtl/cipher_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : cipher_pkg
//  Purpose   : Shared widths, types and helpers for the chaos-cipher datapath.
//  Revision  : 1.0  initial release
// ============================================================================
package cipher_pkg;

    localparam int PIX_W = 8;
    localparam int KS_W  = 23;
    localparam logic [PIX_W-1:0] DEFAULT_IV = 8'hA5;

    typedef logic [PIX_W-1:0] pixel_t;
    typedef logic [KS_W-1:0]  ks_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Only the low byte of a mixer word is used as the per-pixel key.
    function automatic pixel_t ks_to_byte(input ks_t ks);
        return ks[PIX_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/diffusion_inv_core.sv
`default_nettype none
// ============================================================================
//  Module    : diffusion_inv_core
//  Purpose   : Combinational inverse diffusion, p = (ct ^ chain) - k mod 256.
//  Revision  : 1.0  initial release
// ============================================================================
import cipher_pkg::*;

module diffusion_inv_core (
    input  pixel_t ct,
    input  pixel_t chain,
    input  pixel_t k,
    output pixel_t pt
);

    pixel_t w_unchained;

    assign w_unchained = ct ^ chain;
    assign pt          = w_unchained - k;

endmodule
`default_nettype wire

// File: rtl/pixel_diffusion_decryptor.sv
`default_nettype none
// ============================================================================
//  Module    : pixel_diffusion_decryptor
//  Purpose   : Joins keystream and ciphertext, undoes chained diffusion and
//              presents plaintext pixels through a one-entry output register.
//  Revision  : 1.0  initial release
// ============================================================================
import cipher_pkg::*;

module pixel_diffusion_decryptor #(
    parameter int             IMG_PIXELS = 65536,
    parameter logic [7:0]     IV         = cipher_pkg::DEFAULT_IV,
    parameter int             KS_W       = cipher_pkg::KS_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [KS_W-1:0]   ks_data,
    input  logic              ks_valid,
    output logic              ks_ready,
    input  logic [7:0]        ct_data,
    input  logic              ct_valid,
    output logic              ct_ready,
    output logic [7:0]        pt_data,
    output logic              pt_valid,
    input  logic              pt_ready,
    output logic [15:0]       pix_idx,
    output logic              frame_done
);

    localparam int               IDX_W      = 16;
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(IMG_PIXELS - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    pixel_t            r_pt_data;
    pixel_t            r_chain;
    logic [IDX_W-1:0]  r_idx;
    logic              r_last_held;

    pixel_t            w_key;
    pixel_t            w_pt;
    logic              w_slot_free;
    logic              w_consume;
    logic              w_at_last;

    assign w_key       = ks_to_byte(ks_t'(ks_data));
    assign w_slot_free = (r_state == ST_IDLE) || pt_ready;
    // Gating with rst_n keeps the handshake quiet while reset is asserted.
    assign w_consume   = rst_n && ks_valid && ct_valid && w_slot_free;
    assign w_at_last   = (r_idx == c_last_idx);

    diffusion_inv_core u_core (
        .ct    (ct_data),
        .chain (r_chain),
        .k     (w_key),
        .pt    (w_pt)
    );

    always_comb begin
        w_state_nxt = r_state;
        ks_ready    = w_consume;
        ct_ready    = w_consume;
        pt_valid    = (r_state == ST_HOLD);
        frame_done  = rst_n && (r_state == ST_HOLD) && pt_ready && r_last_held;
        if (w_consume) begin
            w_state_nxt = ST_HOLD;
        end else if ((r_state == ST_HOLD) && pt_ready) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_pt_data   <= '0;
            r_chain     <= IV;
            r_idx       <= '0;
            r_last_held <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_consume) begin
                r_pt_data   <= w_pt;
                r_last_held <= w_at_last;
                // Chain follows ciphertext; a new frame restarts from the seed.
                if (w_at_last) begin
                    r_idx   <= '0;
                    r_chain <= IV;
                end else begin
                    r_idx   <= r_idx + 1'b1;
                    r_chain <= ct_data;
                end
            end
        end
    end

    assign pt_data = r_pt_data;
    assign pix_idx = r_idx;

endmodule
`default_nettype wire
